// File: rtl/sa_tile_sched_if.sv
// sa_tile_sched_if: scheduler-to-systolic-array tile handshake
interface sa_tile_sched_if #(parameter int ADDR_W = 12);
  logic              sa_start;
  logic              sa_done;
  logic [ADDR_W-1:0] sa_base_row;
  logic [ADDR_W-1:0] sa_base_col;
  modport master (output sa_start, sa_base_row, sa_base_col, input sa_done);
  modport slave  (input sa_start, sa_base_row, sa_base_col, output sa_done);
endinterface

// File: rtl/sa_tile_sched.sv
// sa_tile_sched: walks an m x n tile grid row-major, issuing one systolic-array job per tile
module sa_tile_sched #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  m_tiles,
  input  logic [CNT_W-1:0]  n_tiles,
  input  logic [ADDR_W-1:0] base_row,
  input  logic [ADDR_W-1:0] base_col,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [ADDR_W-1:0] col_stride,
  sa_tile_sched_if.master   sa,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tile_m,
  output logic [CNT_W-1:0]  tile_n
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;
  state_t            state_q, state_d;
  logic              done_q, done_d, zero_q, zero_d;
  logic [CNT_W-1:0]  tile_m_q, tile_m_d, tile_n_q, tile_n_d, m_q, m_d, n_q, n_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d, bcol_q, bcol_d, rstr_q, rstr_d, cstr_q, cstr_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      tile_m_q <= '0;
      tile_n_q <= '0;
      m_q      <= '0;
      n_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      bcol_q   <= '0;
      rstr_q   <= '0;
      cstr_q   <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      tile_m_q <= tile_m_d;
      tile_n_q <= tile_n_d;
      m_q      <= m_d;
      n_q      <= n_d;
      row_q    <= row_d;
      col_q    <= col_d;
      bcol_q   <= bcol_d;
      rstr_q   <= rstr_d;
      cstr_q   <= cstr_d;
    end
  end
  // zero_q marks the IDLE cycle after an empty job was latched; done rises one cycle later
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    zero_d   = 1'b0;
    tile_m_d = tile_m_q;
    tile_n_d = tile_n_q;
    m_d      = m_q;
    n_d      = n_q;
    row_d    = row_q;
    col_d    = col_q;
    bcol_d   = bcol_q;
    rstr_d   = rstr_q;
    cstr_d   = cstr_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_d = done_q | zero_q;
          if (start) begin
            m_d      = m_tiles;
            n_d      = n_tiles;
            bcol_d   = base_col;
            rstr_d   = row_stride;
            cstr_d   = col_stride;
            row_d    = base_row;
            col_d    = base_col;
            tile_m_d = '0;
            tile_n_d = '0;
            done_d   = 1'b0;
            zero_d   = (m_tiles == '0) || (n_tiles == '0);
            state_d  = zero_d ? IDLE : ISSUE;
          end
        end
        ISSUE: state_d = WAIT;
        WAIT:  state_d = sa.sa_done ? NEXT : WAIT;
        NEXT: begin
          if (tile_n_q != n_q - CNT_W'(1)) begin
            tile_n_d = tile_n_q + CNT_W'(1);
            col_d    = col_q + cstr_q;
            state_d  = ISSUE;
          end else if (tile_m_q != m_q - CNT_W'(1)) begin
            tile_n_d = '0;
            col_d    = bcol_q;
            tile_m_d = tile_m_q + CNT_W'(1);
            row_d    = row_q + rstr_q;
            state_d  = ISSUE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign sa.sa_start    = state_q == ISSUE;
  assign sa.sa_base_row = row_q;
  assign sa.sa_base_col = col_q;
  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign tile_m         = tile_m_q;
  assign tile_n         = tile_n_q;
endmodule

// File: tb/tb_sa_tile_sched.sv
// tb_sa_tile_sched: directed jobs checked cycle-by-cycle against a job-level schedule model
module tb_sa_tile_sched;
  localparam int AW = 12;
  localparam int CW = 8;
  localparam int BIG = 1 << 30;
  typedef struct {int m; int n; int br; int bc; int rs; int cs;} cfg_t;
  typedef struct {int r; int c; int tm; int tn;} tile_t;
  logic clk, rst_n, start, abort, busy, done;
  logic [CW-1:0] m_tiles, n_tiles, tile_m, tile_n;
  logic [AW-1:0] base_row, base_col, row_stride, col_stride;
  sa_tile_sched_if #(.ADDR_W(AW)) sif ();
  sa_tile_sched #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .m_tiles(m_tiles), .n_tiles(n_tiles), .base_row(base_row), .base_col(base_col),
    .row_stride(row_stride), .col_stride(col_stride), .sa(sif),
    .busy(busy), .done(done), .tile_m(tile_m), .tile_n(tile_n));
  int n_tests = 0, n_fail = 0, cyc = 0;
  int js, je, dc, exp_next, li, pend = -1, lat = 5;
  bit prev_done, await_done, resp_en = 1, drove = 0;
  tile_t eq[$];
  tile_t cur;
  int log_q[$];
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic bit busy_exp(input int c);
    return c > js && c < je;
  endfunction
  function automatic bit done_exp(input int c);
    return (c <= js) ? prev_done : (c >= dc);
  endfunction
  function automatic void m_reset();
    js = BIG; je = BIG; dc = BIG; prev_done = 0;
    eq.delete(); exp_next = BIG; await_done = 0;
  endfunction
  // a start is honoured only when the job model is idle; the whole tile list is expanded up front
  function automatic void m_start(input int t, input cfg_t c);
    if (busy_exp(t)) return;
    prev_done = done_exp(t);
    js = t;
    eq.delete();
    await_done = 0;
    exp_next = BIG;
    if (c.m == 0 || c.n == 0) begin
      je = t + 1; dc = t + 2;
    end else begin
      je = BIG; dc = BIG; exp_next = t + 1;
      for (int i = 0; i < c.m; i++)
        for (int j = 0; j < c.n; j++)
          eq.push_back('{(c.br + i * c.rs) & 'hFFF, (c.bc + j * c.cs) & 'hFFF, i, j});
    end
  endfunction
  function automatic void m_sa_done(input int d);
    if (!(busy_exp(d) && await_done && d > li)) return;
    await_done = 0;
    if (eq.size() > 0) exp_next = d + 2;
    else begin je = d + 2; dc = d + 2; end
  endfunction
  function automatic void m_abort(input int a);
    if (!busy_exp(a)) return;
    je = a + 1; dc = BIG; eq.delete(); exp_next = BIG; await_done = 0;
  endfunction
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("sa_start", int'(sif.sa_start), int'(cyc == exp_next));
        chk("busy", int'(busy), int'(busy_exp(cyc)));
        chk("done", int'(done), int'(done_exp(cyc)));
        if (cyc == exp_next && eq.size() > 0) begin
          cur = eq.pop_front();
          chk("issue_row", int'(sif.sa_base_row), cur.r);
          chk("issue_col", int'(sif.sa_base_col), cur.c);
          chk("issue_tm", int'(tile_m), cur.tm);
          chk("issue_tn", int'(tile_n), cur.tn);
          log_q.push_back((int'(sif.sa_base_row) << 12) | int'(sif.sa_base_col));
          await_done = 1; li = cyc; exp_next = BIG;
        end else if (await_done) begin
          chk("hold_row", int'(sif.sa_base_row), cur.r);
          chk("hold_col", int'(sif.sa_base_col), cur.c);
        end
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (drove) begin sif.sa_done = 0; drove = 0; end
      if (resp_en && pend == cyc) begin
        sif.sa_done = 1; drove = 1; pend = -1;
        m_sa_done(cyc);
      end
      if (resp_en && sif.sa_start) pend = cyc + lat;
    end
  end
  task automatic drive_start(input cfg_t c);
    @(negedge clk);
    m_tiles = CW'(c.m); n_tiles = CW'(c.n);
    base_row = AW'(c.br); base_col = AW'(c.bc);
    row_stride = AW'(c.rs); col_stride = AW'(c.cs);
    start = 1;
    m_start(cyc, c);
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    chk("job_done", int'(done), 1);
  endtask
  task automatic wait_sa(input int nth, input int budget);
    int cnt = 0, k = 0;
    forever begin
      if (sif.sa_start) cnt++;
      if (cnt >= nth || k >= budget) break;
      @(negedge clk);
      k++;
    end
    chk("sa_start_seen", int'(cnt >= nth), 1);
  endtask
  task automatic chk_all_zero(input string nm);
    chk({nm, "_sa_start"}, int'(sif.sa_start), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_tile_m"}, int'(tile_m), 0);
    chk({nm, "_tile_n"}, int'(tile_n), 0);
    chk({nm, "_row"}, int'(sif.sa_base_row), 0);
    chk({nm, "_col"}, int'(sif.sa_base_col), 0);
  endtask
  initial begin
    int exp37[6] = '{'h010100, 'h010120, 'h010140, 'h018100, 'h018120, 'h018140};
    int exp41[4] = '{'h100200, 'h100204, 'h110200, 'h110204};
    cfg_t c2;
    rst_n = 0; start = 0; abort = 0; sif.sa_done = 0;
    m_tiles = 0; n_tiles = 0; base_row = 0; base_col = 0; row_stride = 0; col_stride = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);
    // 2x3 grid, array answers 5 cycles after each start
    log_q.delete();
    drive_start('{2, 3, 'h010, 'h100, 'h008, 'h020});
    wait_done(200);
    chk("grid_count", log_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("grid_pair", (i < log_q.size()) ? log_q[i] : -1, exp37[i]);
    // abort while idle leaves done set
    @(negedge clk); abort = 1; m_abort(cyc);
    @(negedge clk); abort = 0;
    repeat (2) @(negedge clk);
    chk("idle_abort_done", int'(done), 1);
    // empty job
    log_q.delete();
    drive_start('{1, 0, 'h020, 'h030, 1, 1});
    chk("zero_done_t1", int'(done), 0);
    @(negedge clk);
    chk("zero_done_t2", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("zero_no_issue", log_q.size(), 0);
    // column address wrap
    log_q.delete();
    drive_start('{1, 2, 'h000, 'hFF0, 'h000, 'h020});
    wait_done(100);
    chk("wrap_count", log_q.size(), 2);
    chk("wrap_col", (log_q.size() > 1) ? (log_q[1] & 'hFFF) : -1, 'h010);
    repeat (3) @(negedge clk);
    // abort in second WAIT cycle of tile (0,1), colliding with sa_done
    log_q.delete();
    drive_start('{2, 3, 'h010, 'h100, 'h008, 'h020});
    wait_sa(2, 50);
    @(negedge clk);
    @(negedge clk);
    abort = 1; sif.sa_done = 1;
    m_abort(cyc); m_sa_done(cyc);
    @(negedge clk);
    abort = 0; sif.sa_done = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (15) @(negedge clk);
    chk("abort_issues", log_q.size(), 2);
    // restart while busy and stray sa_done in ISSUE
    log_q.delete();
    drive_start('{2, 2, 'h100, 'h200, 'h010, 'h004});
    wait_sa(1, 10);
    c2 = '{1, 1, 'hABC, 'h123, 'h001, 'h001};
    m_tiles = 1; n_tiles = 1; base_row = 'hABC; base_col = 'h123; row_stride = 1; col_stride = 1;
    start = 1; sif.sa_done = 1;
    m_start(cyc, c2); m_sa_done(cyc);
    @(negedge clk);
    start = 0; sif.sa_done = 0;
    wait_done(200);
    chk("ignore_count", log_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("ignore_pair", (i < log_q.size()) ? log_q[i] : -1, exp41[i]);
    // reset mid-WAIT
    log_q.delete();
    drive_start('{2, 2, 'h040, 'h050, 'h001, 'h001});
    wait_sa(1, 10);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0; resp_en = 0; pend = -1;
    m_reset();
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1; resp_en = 1;
    repeat (20) @(negedge clk);
    chk("rst_no_issue", log_q.size(), 1);
    chk("rst_busy", int'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
